// File: rtl/fifo_pkg.sv
// Shared sizing helpers and error-flag record for the single-clock programmable FIFO.
// No logic of its own; depth, count width and the sticky error pair are defined here.
package fifo_pkg;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  // Occupancy and pointers need one extra bit so that a completely full FIFO is representable.
  function automatic int fifo_cw(input int asize);
    return asize + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_sync_mem.sv
// Storage array: synchronous write, asynchronous read, zero-latency read port.
// No flow control here; the caller gates the write enable on fullness.
module fifo_sync_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [fifo_depth(ASIZE)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with live thresholds, occupancy count and sticky errors; read data 1 cycle after racc (FWFT=0) or 0 (FWFT=1).
// Writes are dropped while full and reads ignored while empty, each raising a sticky error.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4,
  parameter int FWFT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic [ASIZE:0]   aempty_thresh,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int            DEPTH   = fifo_depth(ASIZE);
  localparam int            CW      = fifo_cw(ASIZE);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0]    wptr;
  logic [CW-1:0]    rptr;
  logic [CW-1:0]    cnt_q;
  fifo_err_t        err_q;
  logic             wacc;
  logic             racc;
  logic [DSIZE-1:0] mem_rdata;

  // Flags come only from the registered count, so an out-of-range threshold simply never/always matches.
  assign rempty        = (cnt_q == '0);
  assign wfull         = (cnt_q == DEPTH_C);
  assign walmost_full  = (cnt_q >= afull_thresh);
  assign ralmost_empty = (cnt_q <= aempty_thresh);

  assign wacc = winc && !wfull;
  assign racc = rinc && !rempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      if (wacc) begin
        wptr <= wptr + ONE;
      end
      if (racc) begin
        rptr <= rptr + ONE;
      end
      case ({wacc, racc})
        2'b10:   cnt_q <= cnt_q + ONE;
        2'b01:   cnt_q <= cnt_q - ONE;
        default: cnt_q <= cnt_q;
      endcase
      // A fresh error in the same cycle as clr_err must survive the clear.
      err_q.overflow  <= (winc && wfull)  || (err_q.overflow  && !clr_err);
      err_q.underflow <= (rinc && rempty) || (err_q.underflow && !clr_err);
    end
  end

  assign count     = cnt_q;
  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

  fifo_sync_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (wacc),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = mem_rdata;
    end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (racc) begin
          rdata_q <= mem_rdata;
        end
      end
      assign rdata = rdata_q;
    end
  endgenerate

  // The wide pointers differ by exactly the occupancy; a divergence means the count logic slipped.
  ptr_count_consistent: assert property (@(posedge clk) disable iff (rst) cnt_q == CW'(wptr - rptr));

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Scoreboard bench: one standard-mode and one FWFT instance, DEPTH=4, directed stimulus.
// Expected read data is queued at issue time and popped by per-instance monitors.
module tb_fifo_sync_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       winc0 = 0, rinc0 = 0, clr0 = 0;
  logic       winc1 = 0, rinc1 = 0, clr1 = 0;
  logic [2:0] af0 = 3'd3, ae0 = 3'd1, af1 = 3'd0, ae1 = 3'd1;

  logic       wfull0, wafull0, rempty0, raempty0, ovf0, unf0;
  logic       wfull1, wafull1, rempty1, raempty1, ovf1, unf1;
  logic [7:0] rdata0, rdata1;
  logic [2:0] count0, count1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic       pend0;

  always #5 clk = ~clk;

  fifo_sync_prog #(.DSIZE(8), .ASIZE(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wdata(wdata0), .winc(winc0), .wfull(wfull0),
    .walmost_full(wafull0), .rinc(rinc0), .rdata(rdata0), .rempty(rempty0),
    .ralmost_empty(raempty0), .afull_thresh(af0), .aempty_thresh(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0), .clr_err(clr0)
  );

  fifo_sync_prog #(.DSIZE(8), .ASIZE(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata1), .winc(winc1), .wfull(wfull1),
    .walmost_full(wafull1), .rinc(rinc1), .rdata(rdata1), .rempty(rempty1),
    .ralmost_empty(raempty1), .afull_thresh(af1), .aempty_thresh(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1), .clr_err(clr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Standard mode: data belongs to the read accepted at the previous edge.
  always @(posedge clk or posedge rst) begin
    if (rst) pend0 <= 1'b0;
    else     pend0 <= rinc0 && !rempty0;
  end

  always @(negedge clk) begin
    if (!rst && pend0) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd0_unexpected: got %0h expected no read", rdata0);
      end else begin
        chk("rd0", rdata0, exp_q0.pop_front());
      end
    end
  end

  // FWFT mode: data is presented during the cycle the read is accepted.
  always @(negedge clk) begin
    if (!rst && rinc1 && !rempty1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd1_unexpected: got %0h expected no read", rdata1);
      end else begin
        chk("rd1", rdata1, exp_q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fill_d  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [2:0] cnt_up  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       afu_up  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       ful_up  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] cnt_dn  [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    logic       aem_dn  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       emp_dn  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] ov_d    [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] fw_d    [3] = '{8'hD1, 8'hD2, 8'hD3};

    // Power-on reset state, including almost-full at a zero threshold.
    #2;
    chk("rst_count0",   count0,   0);
    chk("rst_rempty0",  rempty0,  1);
    chk("rst_wfull0",   wfull0,   0);
    chk("rst_raempty0", raempty0, 1);
    chk("rst_wafull0",  wafull0,  0);
    chk("rst_wafull1_thr0", wafull1, 1);
    chk("rst_rempty1",  rempty1,  1);
    af1 = 3'd3;
    #1 rst = 1'b0;
    step();

    // Mid-stream asynchronous reset.
    winc0 = 1; wdata0 = 8'hAA; step();
    wdata0 = 8'hBB; step();
    winc0 = 0; rinc0 = 1; exp_q0.push_back(8'hAA); step();
    rinc0 = 0; step();
    chk("pre_rst_count0", count0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_count0",   count0,   0);
    chk("mrst_rempty0",  rempty0,  1);
    chk("mrst_wfull0",   wfull0,   0);
    chk("mrst_raempty0", raempty0, 1);
    chk("mrst_rdata0",   rdata0,   8'h00);
    chk("mrst_ovf0",     ovf0,     0);
    chk("mrst_unf0",     unf0,     0);
    #2 rst = 1'b0;
    step();

    // Fill and drain in standard mode.
    for (int i = 0; i < 4; i++) begin
      winc0 = 1; wdata0 = fill_d[i]; step();
      chk("fill_count",  count0,  cnt_up[i]);
      chk("fill_wafull", wafull0, afu_up[i]);
      chk("fill_wfull",  wfull0,  ful_up[i]);
    end
    winc0 = 0;
    af0 = 3'd5; ae0 = 3'd4; #1;
    chk("thr_afull_gt_depth",   wafull0,  0);
    chk("thr_aempty_ge_depth",  raempty0, 1);
    af0 = 3'd3; ae0 = 3'd1;
    for (int i = 0; i < 4; i++) begin
      rinc0 = 1; exp_q0.push_back(fill_d[i]); step();
      chk("drain_count",   count0,   cnt_dn[i]);
      chk("drain_raempty", raempty0, aem_dn[i]);
      chk("drain_rempty",  rempty0,  emp_dn[i]);
    end
    rinc0 = 0; step();

    // Simultaneous read and write while full, then clear behaviour.
    for (int i = 0; i < 4; i++) begin
      winc0 = 1; wdata0 = ov_d[i]; step();
    end
    wdata0 = 8'h55; rinc0 = 1; exp_q0.push_back(8'h01); step();
    winc0 = 0; rinc0 = 0;
    chk("ovf_count", count0, 3);
    chk("ovf_set",   ovf0,   1);
    chk("ovf_unf",   unf0,   0);
    clr0 = 1; step();
    clr0 = 0;
    chk("ovf_clr", ovf0, 0);
    winc0 = 1; wdata0 = 8'h66; step();
    chk("refill_wfull", wfull0, 1);
    clr0 = 1; wdata0 = 8'h99; step();
    clr0 = 0; winc0 = 0;
    chk("ovf_set_wins", ovf0,   1);
    chk("ovf_keep_cnt", count0, 4);
    rinc0 = 1;
    exp_q0.push_back(8'h02); step();
    exp_q0.push_back(8'h03); step();
    exp_q0.push_back(8'h04); step();
    exp_q0.push_back(8'h66); step();
    rinc0 = 0; clr0 = 1; step();
    clr0 = 0;
    chk("ovf_cleared", ovf0, 0);

    // Simultaneous read and write while empty.
    winc0 = 1; rinc0 = 1; wdata0 = 8'h77; step();
    winc0 = 0; rinc0 = 0;
    chk("unf_count",  count0,  1);
    chk("unf_set",    unf0,    1);
    chk("unf_rempty", rempty0, 0);
    rinc0 = 1; exp_q0.push_back(8'h77); step();
    rinc0 = 0; clr0 = 1; step();
    clr0 = 0;
    chk("unf_cleared", unf0,   0);
    chk("unf_count0",  count0, 0);

    // Steady pair traffic at count 2, pointers wrap repeatedly.
    winc0 = 1; wdata0 = 8'hB0; step();
    wdata0 = 8'hB1; step();
    for (int i = 0; i < 10; i++) begin
      rinc0 = 1; wdata0 = 8'hC0 + 8'(i);
      exp_q0.push_back(i == 0 ? 8'hB0 : i == 1 ? 8'hB1 : 8'hC0 + 8'(i - 2));
      step();
      chk("wrap_count",   count0,   2);
      chk("wrap_flags",   {wfull0, wafull0, rempty0, raempty0, ovf0, unf0}, 6'b0);
    end
    winc0 = 0;
    exp_q0.push_back(8'hC8); step();
    exp_q0.push_back(8'hC9); step();
    rinc0 = 0; step();
    chk("wrap_end_count", count0, 0);

    // First-word-fall-through instance.
    winc1 = 1; wdata1 = 8'hA5; step();
    winc1 = 0;
    chk("fwft_rempty", rempty1, 0);
    chk("fwft_rdata",  rdata1,  8'hA5);
    rinc1 = 1; exp_q1.push_back(8'hA5); step();
    rinc1 = 0;
    chk("fwft_empty_after", rempty1, 1);
    for (int i = 0; i < 3; i++) begin
      winc1 = 1; wdata1 = fw_d[i]; step();
    end
    winc1 = 0;
    rinc1 = 1;
    for (int i = 0; i < 3; i++) begin
      exp_q1.push_back(fw_d[i]); step();
    end
    rinc1 = 0; step();
    chk("fwft_count_end", count1, 0);

    step();
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
